// File: rtl/vector_fifo_if.sv
// rtl/vector_fifo_if.sv - handshake and status bundle for vector_fifo
interface vector_fifo_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IB_DEPTH   = 4
);
  localparam int OCC_W = $clog2(IB_DEPTH + 1);

  logic                            enqueue;
  logic                            eof_in;
  logic [N-1:0][DATA_WIDTH-1:0]    vector_in;
  logic                            dequeue;
  logic                            valid_out;
  logic                            eof_out;
  logic [N-1:0][DATA_WIDTH-1:0]    vector_out;
  logic                            empty;
  logic                            full;
  logic                            almost_full;
  logic [OCC_W-1:0]                occupancy;
  logic [15:0]                     drop_count;

  modport master (
    output enqueue, eof_in, vector_in, dequeue,
    input  valid_out, eof_out, vector_out, empty, full, almost_full, occupancy, drop_count
  );

  modport slave (
    input  enqueue, eof_in, vector_in, dequeue,
    output valid_out, eof_out, vector_out, empty, full, almost_full, occupancy, drop_count
  );
endinterface

// File: rtl/vector_fifo.sv
// rtl/vector_fifo.sv - circular-buffer vector FIFO with eof tag, 1-cycle read; optional VECTOR_FIFO_DROP_STATS_EN drop counter
module vector_fifo #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IB_DEPTH   = 4,
  parameter int AF_THRESH  = IB_DEPTH - 1
) (
  input  logic          clk,
  input  logic          reset,
  vector_fifo_if.slave  bus
);
  localparam int OCC_W = $clog2(IB_DEPTH + 1);
  localparam int PTR_W = (IB_DEPTH > 1) ? $clog2(IB_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(IB_DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(IB_DEPTH);
  localparam logic [OCC_W-1:0] AF_OCC    = OCC_W'(AF_THRESH);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  vec_t             mem_vec [IB_DEPTH];
  logic             mem_eof [IB_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             empty;
  logic             full;
  logic             deq_acc;
  logic             enq_acc;
  logic             valid_q;
  logic             eof_q;
  vec_t             vec_q;

  assign empty = (occ == '0);
  assign full  = (occ == DEPTH_OCC);

  // A dequeue on an empty buffer is ignored even if an enqueue lands in the
  // same cycle, so there is never a write-to-read bypass.
  assign deq_acc = bus.dequeue && !empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign enq_acc = bus.enqueue && (!full || deq_acc);

  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (occ >= AF_OCC);
  assign bus.occupancy   = occ;
  assign bus.valid_out   = valid_q;
  assign bus.eof_out     = eof_q;
  assign bus.vector_out  = vec_q;

  // Pointer and occupancy bookkeeping; pointers wrap at IB_DEPTH-1 so any depth works.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (enq_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (deq_acc) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      if (enq_acc && !deq_acc)      occ <= occ + OCC_W'(1);
      else if (deq_acc && !enq_acc) occ <= occ - OCC_W'(1);
    end
  end

  // Entry storage; contents are left untouched by reset, the pointers make them stale.
  always_ff @(posedge clk) begin
    if (!reset && enq_acc) begin
      mem_vec[wr_ptr] <= bus.vector_in;
      mem_eof[wr_ptr] <= bus.eof_in;
    end
  end

  // Registered read port: data and eof appear one cycle after the accepted dequeue and hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      valid_q <= deq_acc;
      if (deq_acc) begin
        vec_q <= mem_vec[rd_ptr];
        eof_q <= mem_eof[rd_ptr];
      end
    end
  end

`ifdef VECTOR_FIFO_DROP_STATS_EN
  logic [15:0] drop_q;

  // Count enqueues turned away by a full buffer, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (bus.enqueue && !enq_acc && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_vector_fifo.sv
// tb/tb_vector_fifo.sv - self-checking bench for vector_fifo against a queue model
module tb_vector_fifo;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vector_fifo_if #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEPTH)) vif ();

  vector_fifo #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  int checks   = 0;
  int failures = 0;

  logic [32:0] model_q [$];
  logic        exp_valid;
  logic        exp_eof;
  logic [31:0] exp_vec;
  int          exp_drops;

  // One clock of stimulus; the model advances from the FIFO rules using the pre-edge fill level.
  task automatic drive(input logic enq, input logic eof, input logic [31:0] data, input logic deq);
    bit deq_ok;
    bit enq_ok;
    vif.enqueue   = enq;
    vif.eof_in    = eof;
    vif.vector_in = data;
    vif.dequeue   = deq;
    deq_ok = deq && (model_q.size() > 0);
    enq_ok = enq && ((model_q.size() < DEPTH) || deq_ok);
    @(posedge clk);
    #1;
    if (reset) begin
      model_q.delete();
      exp_valid = 1'b0;
      exp_eof   = 1'b0;
      exp_vec   = '0;
      exp_drops = 0;
    end else begin
      exp_valid = deq_ok;
      if (deq_ok) {exp_eof, exp_vec} = model_q.pop_front();
      if (enq_ok) model_q.push_back({eof, data});
`ifdef VECTOR_FIFO_DROP_STATS_EN
      else if (enq && exp_drops < 65535) exp_drops++;
`endif
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, $urandom, 1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (vif.occupancy !== '0) begin failures++; $display("FAIL reset_occ: got %0d want 0", vif.occupancy); end
    checks++; if (vif.empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", vif.empty); end
    checks++; if (vif.full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", vif.full); end
    checks++; if (vif.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", vif.valid_out); end
    checks++; if (vif.vector_out !== 32'h0 || vif.eof_out !== 1'b0) begin failures++; $display("FAIL reset_data: got %h/%b want 0/0", vif.vector_out, vif.eof_out); end
    checks++; if (vif.drop_count !== 16'h0) begin failures++; $display("FAIL reset_drops: got %0d want 0", vif.drop_count); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      d = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
      drive(1'b1, 1'b0, d, 1'b0);
      checks++; if (vif.occupancy !== OCC_W'(i+1)) begin failures++; $display("FAIL fill_occ%0d: got %0d want %0d", i, vif.occupancy, i+1); end
      checks++; if (vif.almost_full !== (i+1 >= AF)) begin failures++; $display("FAIL fill_af%0d: got %b want %b", i, vif.almost_full, (i+1 >= AF)); end
      checks++; if (vif.full !== (i == 3)) begin failures++; $display("FAIL fill_full%0d: got %b want %b", i, vif.full, (i == 3)); end
    end
    for (int i = 0; i < 4; i++) begin
      d = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
      drive(1'b0, 1'b0, '0, 1'b1);
      checks++; if (vif.valid_out !== 1'b1 || vif.vector_out !== d) begin failures++; $display("FAIL drain%0d: got v=%b %h want v=1 %h", i, vif.valid_out, vif.vector_out, d); end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    checks++; if (vif.valid_out !== 1'b0 || vif.empty !== 1'b1) begin failures++; $display("FAIL drain_end: got v=%b e=%b want v=0 e=1", vif.valid_out, vif.empty); end
  endtask

  task automatic test_overflow();
    logic [31:0] saved [4];
    logic [15:0] want_drops;
`ifdef VECTOR_FIFO_DROP_STATS_EN
    want_drops = 16'd1;
`else
    want_drops = 16'd0;
`endif
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      saved[i] = $urandom;
      drive(1'b1, 1'b0, saved[i], 1'b0);
    end
    drive(1'b1, 1'b1, $urandom, 1'b0);
    checks++; if (vif.occupancy !== OCC_W'(4) || vif.full !== 1'b1) begin failures++; $display("FAIL ovf_occ: got %0d full=%b want 4 full=1", vif.occupancy, vif.full); end
    checks++; if (vif.drop_count !== want_drops) begin failures++; $display("FAIL ovf_drops: got %0d want %0d", vif.drop_count, want_drops); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      checks++; if (vif.valid_out !== 1'b1 || vif.vector_out !== saved[i] || vif.eof_out !== 1'b0) begin failures++; $display("FAIL ovf_data%0d: got v=%b %h eof=%b want v=1 %h eof=0", i, vif.valid_out, vif.vector_out, vif.eof_out, saved[i]); end
    end
  endtask

  task automatic test_simul_full();
    logic [31:0] saved [4];
    logic [31:0] a;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      saved[i] = $urandom;
      drive(1'b1, 1'b0, saved[i], 1'b0);
    end
    a = $urandom;
    drive(1'b1, 1'b0, a, 1'b1);
    checks++; if (vif.occupancy !== OCC_W'(4)) begin failures++; $display("FAIL sfull_occ: got %0d want 4", vif.occupancy); end
    checks++; if (vif.valid_out !== 1'b1 || vif.vector_out !== saved[0]) begin failures++; $display("FAIL sfull_head: got v=%b %h want v=1 %h", vif.valid_out, vif.vector_out, saved[0]); end
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      checks++; if (vif.vector_out !== ((i == 4) ? a : saved[i])) begin failures++; $display("FAIL sfull_order%0d: got %h want %h", i, vif.vector_out, (i == 4) ? a : saved[i]); end
    end
  endtask

  task automatic test_simul_empty();
    logic [31:0] a;
    apply_reset();
    a = $urandom;
    drive(1'b1, 1'b0, a, 1'b1);
    checks++; if (vif.occupancy !== OCC_W'(1) || vif.valid_out !== 1'b0) begin failures++; $display("FAIL sempty: got occ=%0d v=%b want occ=1 v=0", vif.occupancy, vif.valid_out); end
    drive(1'b0, 1'b0, '0, 1'b1);
    checks++; if (vif.valid_out !== 1'b1 || vif.vector_out !== a || vif.empty !== 1'b1) begin failures++; $display("FAIL sempty_read: got v=%b %h e=%b want v=1 %h e=1", vif.valid_out, vif.vector_out, vif.empty, a); end
  endtask

  task automatic test_wrap_eof();
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      drive(1'b1, (i == 6), d, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b1);
      checks++; if (vif.valid_out !== 1'b1 || vif.vector_out !== d || vif.eof_out !== (i == 6)) begin failures++; $display("FAIL wrap%0d: got v=%b %h eof=%b want v=1 %h eof=%b", i, vif.valid_out, vif.vector_out, vif.eof_out, d, (i == 6)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, $urandom, 1'b0);
    checks++; if (vif.occupancy !== OCC_W'(3)) begin failures++; $display("FAIL rmid_pre: got %0d want 3", vif.occupancy); end
    apply_reset();
    checks++; if (vif.occupancy !== '0 || vif.empty !== 1'b1 || vif.valid_out !== 1'b0) begin failures++; $display("FAIL rmid_clear: got occ=%0d e=%b v=%b want 0/1/0", vif.occupancy, vif.empty, vif.valid_out); end
    d = $urandom;
    drive(1'b1, 1'b0, d, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    checks++; if (vif.valid_out !== 1'b1 || vif.vector_out !== d || vif.eof_out !== 1'b0) begin failures++; $display("FAIL rmid_new: got v=%b %h eof=%b want v=1 %h eof=0", vif.valid_out, vif.vector_out, vif.eof_out, d); end
    drive(1'b0, 1'b0, '0, 1'b1);
    checks++; if (vif.valid_out !== 1'b0 || vif.empty !== 1'b1) begin failures++; $display("FAIL rmid_stale: got v=%b e=%b want v=0 e=1", vif.valid_out, vif.empty); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive(($urandom_range(0, 99) < 60), $urandom_range(0, 1), $urandom, ($urandom_range(0, 99) < 45));
      reset = 1'b0;
      checks++; if (vif.valid_out !== exp_valid) begin failures++; $display("FAIL rnd_valid@%0d: got %b want %b", c, vif.valid_out, exp_valid); end
      checks++; if (vif.vector_out !== exp_vec || vif.eof_out !== exp_eof) begin failures++; $display("FAIL rnd_data@%0d: got %h/%b want %h/%b", c, vif.vector_out, vif.eof_out, exp_vec, exp_eof); end
      checks++; if (vif.occupancy !== OCC_W'(model_q.size())) begin failures++; $display("FAIL rnd_occ@%0d: got %0d want %0d", c, vif.occupancy, model_q.size()); end
      checks++; if (vif.empty !== (model_q.size() == 0) || vif.full !== (model_q.size() == DEPTH) || vif.almost_full !== (model_q.size() >= AF)) begin failures++; $display("FAIL rnd_flags@%0d: got e=%b f=%b af=%b for occupancy %0d", c, vif.empty, vif.full, vif.almost_full, model_q.size()); end
      checks++; if (vif.drop_count !== 16'(exp_drops)) begin failures++; $display("FAIL rnd_drops@%0d: got %0d want %0d", c, vif.drop_count, exp_drops); end
    end
  endtask

  initial begin
    reset         = 1'b1;
    vif.enqueue   = 1'b0;
    vif.eof_in    = 1'b0;
    vif.vector_in = '0;
    vif.dequeue   = 1'b0;
    model_q.delete();
    exp_valid = 1'b0;
    exp_eof   = 1'b0;
    exp_vec   = '0;
    exp_drops = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simul_full();
    test_simul_empty();
    test_wrap_eof();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_fifo.md
VECTOR_FIFO -- requirements
Module: vector_fifo

Interface
REQ-001 SHALL have parameter N, default 8, vector lanes per entry.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per lane.
REQ-003 SHALL have parameter IB_DEPTH, default 4, entry count; any integer >=2, not required to be a power of two.
REQ-004 SHALL have parameter AF_THRESH, default IB_DEPTH-1, almost-full occupancy level.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, active-high reset sampled on clk.
REQ-006 SHALL have enqueue, input, 1 bit: write request.
REQ-007 SHALL have eof_in, input, 1 bit: end-of-frame tag stored with the entry.
REQ-008 SHALL have vector_in, input, N x DATA_WIDTH: write data.
REQ-009 SHALL have dequeue, input, 1 bit: read request.
REQ-010 SHALL have valid_out, output, 1 bit: vector_out/eof_out hold a dequeued entry.
REQ-011 SHALL have eof_out, output, 1 bit: eof tag of the dequeued entry.
REQ-012 SHALL have vector_out, output, N x DATA_WIDTH: dequeued data.
REQ-013 SHALL have the status outputs:
- empty, output, 1 bit.
- full, output, 1 bit.
- almost_full, output, 1 bit.
REQ-014 SHALL have occupancy, output, $clog2(IB_DEPTH+1) bits: stored entry count.
REQ-015 SHALL have drop_count, output, 16 bits: rejected-enqueue counter (see Configuration).

Function
REQ-016 SHALL store entries in a circular buffer with separate write and read pointers, each wrapping from IB_DEPTH-1 to 0.
REQ-017 SHALL track occupancy with an explicit counter; empty = (occupancy==0), full = (occupancy==IB_DEPTH), almost_full = (occupancy>=AF_THRESH); all combinational from registers.
REQ-018 SHALL accept a dequeue when dequeue=1 and empty=0; a dequeue while empty is ignored with no state change.
REQ-019 SHALL accept an enqueue when enqueue=1 and either full=0 or a dequeue is accepted in the same cycle.
REQ-020 SHALL reject an enqueue while full with no simultaneous accepted dequeue; the data is discarded and the stored contents are unchanged.
REQ-021 SHALL ignore the dequeue when enqueue and dequeue occur simultaneously on an empty buffer: the enqueue is accepted, and there is no write-to-read bypass.
REQ-022 SHALL store eof_in together with vector_in in the same entry and return it on eof_out with that entry.
REQ-023 SHALL produce read data with a latency of 1 cycle: for a dequeue accepted at edge k, valid_out=1 after edge k+1 with that entry's data and eof tag.
REQ-024 SHALL hold valid_out=0 in every cycle without a dequeue accepted at the preceding edge; vector_out and eof_out hold their last values when valid_out=0.
REQ-025 SHALL update occupancy per cycle: +1 for enqueue only, -1 for dequeue only, unchanged for both or neither.
REQ-026 SHALL preserve FIFO order across any number of pointer wraps.

Reset
REQ-027 SHALL, while reset=1, clear both pointers, occupancy, valid_out, eof_out, vector_out and drop_count to 0; empty=1, full=0.
REQ-028 SHALL ignore enqueue and dequeue in any cycle with reset=1; a reset mid-operation discards all stored entries.
REQ-029 SHALL NOT require stored array contents to be cleared by reset.

Configuration
REQ-030 SHALL, with macro VECTOR_FIFO_DROP_STATS_EN defined, increment drop_count by 1 on each rejected enqueue, saturating at 16'hFFFF.
REQ-031 SHALL, without VECTOR_FIFO_DROP_STATS_EN, tie drop_count to 0 and synthesise no counter logic; the port list is identical in both builds.

Verification
Bench parameters: N=4, DATA_WIDTH=8, IB_DEPTH=4, AF_THRESH=3.
REQ-032 SHALL cover fill and drain:
- Stimulus: enqueue lanes {1,2,3,4} to {13,14,15,16}, 4 cycles, then dequeue x4.
- Required: full=1 and occupancy=4 after the 4th write; almost_full=1 at occupancy 3.
- Required: outputs return in order, each 1 cycle after its dequeue; empty=1 at the end.
REQ-033 SHALL cover overflow: a 5th enqueue while full -> rejected, contents unchanged; drop_count=1 with the macro, 0 without.
REQ-034 SHALL cover simultaneous access when full: enqueue {A0,...} with dequeue at occupancy 4 -> both accepted; occupancy stays 4; the head entry is output; the new entry is read last.
REQ-035 SHALL cover simultaneous access when empty: enqueue+dequeue at occupancy 0 -> occupancy=1, valid_out=0 next cycle.
REQ-036 SHALL cover wrap and EOF: 10 interleaved enqueue/dequeue pairs with eof_in=1 on the 7th entry -> order preserved; eof_out=1 only with the 7th entry.
REQ-037 SHALL cover reset mid-operation: reset at occupancy 3 -> occupancy=0, empty=1, valid_out=0; the next enqueue/dequeue returns only the new data.
